// File: rtl/song_sequencer.sv
// Note-table driven song sequencer: fetches (half-period, duration) entries and
// times tone/gap intervals. Define SONG_LOOP_EN to honour the loop input at song end.
module song_sequencer #(
    parameter int BEAT_DIV   = 25000000,
    parameter int GAP_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [19:0] wr_data,
    output logic [14:0] note_value,
    output logic        note_enable,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [31:0] BEAT_LAST = 32'(BEAT_DIV - 1);
    // The FETCH cycle counts as the final silent cycle, so GAP itself lasts GAP_CYCLES-1.
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 2);
    localparam bit          GAP_SKIP  = (GAP_CYCLES == 1);

    logic [19:0] mem_r [32];
    logic [19:0] rd_data_r;

    state_t      state_r, state_s;
    logic [4:0]  addr_r, addr_s;
    logic [31:0] beat_cnt_r, beat_cnt_s;
    logic [31:0] cyc_cnt_r, cyc_cnt_s;
    logic [31:0] gap_cnt_r, gap_cnt_s;
    logic [14:0] note_value_r, note_value_s;
    logic        note_enable_r, note_enable_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        note_done_s;
    logic        song_end_s;
    logic        loop_act_s;

`ifdef SONG_LOOP_EN
    assign loop_act_s = loop;
`else
    logic unused_loop_s;
    assign loop_act_s    = 1'b0;
    assign unused_loop_s = loop;
`endif

    // Note table: read of the upcoming address, old data returned on a same-address write.
    always_ff @(posedge clk) begin
        rd_data_r <= mem_r[addr_s];
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s       = state_r;
        addr_s        = addr_r;
        beat_cnt_s    = beat_cnt_r;
        cyc_cnt_s     = cyc_cnt_r;
        gap_cnt_s     = gap_cnt_r;
        note_value_s  = note_value_r;
        note_enable_s = note_enable_r;
        done_s        = 1'b0;
        note_done_s   = 1'b0;
        song_end_s    = 1'b0;

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s    = FETCH;
                    addr_s     = 5'd0;
                    beat_cnt_s = 32'd0;
                    cyc_cnt_s  = 32'd0;
                    gap_cnt_s  = 32'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (rd_data_r[4:0] == 5'd0) begin
                    song_end_s = 1'b1;
                end else begin
                    note_value_s  = rd_data_r[19:5];
                    note_enable_s = (rd_data_r[19:5] != 15'd0);
                    beat_cnt_s    = {27'd0, rd_data_r[4:0]};
                    cyc_cnt_s     = 32'd0;
                    state_s       = PLAY;
                end
            end
            PLAY: begin
                if (cyc_cnt_r == BEAT_LAST) begin
                    cyc_cnt_s = 32'd0;
                    if (beat_cnt_r == 32'd1) begin
                        note_enable_s = 1'b0;
                        if (GAP_SKIP) begin
                            note_done_s = 1'b1;
                        end else begin
                            state_s   = GAP;
                            gap_cnt_s = 32'd0;
                        end
                    end else begin
                        beat_cnt_s = beat_cnt_r - 32'd1;
                    end
                end else begin
                    cyc_cnt_s = cyc_cnt_r + 32'd1;
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    note_done_s = 1'b1;
                end else begin
                    gap_cnt_s = gap_cnt_r + 32'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (note_done_s) begin
            if (addr_r == 5'd31) begin
                song_end_s = 1'b1;
            end else begin
                addr_s  = addr_r + 5'd1;
                state_s = FETCH;
            end
        end else begin
            note_done_s = 1'b0;
        end

        if (song_end_s) begin
            done_s        = 1'b1;
            note_enable_s = 1'b0;
            addr_s        = 5'd0;
            beat_cnt_s    = 32'd0;
            cyc_cnt_s     = 32'd0;
            gap_cnt_s     = 32'd0;
            state_s       = loop_act_s ? FETCH : IDLE;
        end else begin
            song_end_s = 1'b0;
        end

        // Abort wins over everything, including a simultaneous start or song end.
        if (stop) begin
            state_s       = IDLE;
            addr_s        = 5'd0;
            beat_cnt_s    = 32'd0;
            cyc_cnt_s     = 32'd0;
            gap_cnt_s     = 32'd0;
            note_value_s  = 15'd0;
            note_enable_s = 1'b0;
            done_s        = 1'b0;
        end else begin
            done_s = done_s;
        end

        busy_s = (state_s != IDLE);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            addr_r        <= 5'd0;
            beat_cnt_r    <= 32'd0;
            cyc_cnt_r     <= 32'd0;
            gap_cnt_r     <= 32'd0;
            note_value_r  <= 15'd0;
            note_enable_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            addr_r        <= addr_s;
            beat_cnt_r    <= beat_cnt_s;
            cyc_cnt_r     <= cyc_cnt_s;
            gap_cnt_r     <= gap_cnt_s;
            note_value_r  <= note_value_s;
            note_enable_r <= note_enable_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
        end
    end

    assign note_value  = note_value_r;
    assign note_enable = note_enable_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: per-cycle expected timeline built from the note table.
module tb_song_sequencer;

    localparam int BD = 4;
    localparam int GC = 2;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, loop, wr_en;
    logic [4:0]  wr_addr;
    logic [19:0] wr_data;
    logic [14:0] note_value;
    logic        note_enable, busy, done;

    int checks = 0;
    int errors = 0;

    logic [19:0] tbl [32];

    typedef struct packed {
        logic        play;
        logic        en;
        logic        bz;
        logic        dn;
        logic [14:0] val;
    } obs_t;

    obs_t exp_q[$];

    song_sequencer #(.BEAT_DIV(BD), .GAP_CYCLES(GC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .note_value(note_value), .note_enable(note_enable), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic play, input logic en, input logic bz,
                                input logic dn, input logic [14:0] val);
        obs_t o;
        o.play = play; o.en = en; o.bz = bz; o.dn = dn; o.val = val;
        return o;
    endfunction

    // One pass through the table: each note is dur*BD cycles, then GC silent cycles
    // (the last of which is the next fetch); terminator or entry 31 ends the song.
    task automatic gen_pass(input bit with_fetch, input bit end_busy);
        int d;
        logic [14:0] v;
        if (with_fetch) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 15'd0));
        for (int i = 0; i < 32; i++) begin
            d = int'(tbl[i][4:0]);
            v = tbl[i][19:5];
            if (d == 0) begin
                exp_q.push_back(mk(1'b0, 1'b0, end_busy, 1'b1, 15'd0));
                return;
            end
            repeat (d * BD) exp_q.push_back(mk(1'b1, v != 15'd0, 1'b1, 1'b0, v));
            repeat (GC - 1) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 15'd0));
            if (i == 31) begin
                exp_q.push_back(mk(1'b0, 1'b0, end_busy, 1'b1, 15'd0));
                return;
            end
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 15'd0));
        end
    endtask

    task automatic write_entry(input int a, input logic [14:0] v, input logic [4:0] d);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_data = {v, d};
        tbl[a]  = {v, d};
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    // Pulse start, then compare every cycle against exp_q; start is re-asserted
    // randomly while busy to show it is ignored.
    task automatic run_check(input string name, input bit rand_start);
        obs_t e;
        start = 1'b1;
        for (int j = 0; j < exp_q.size(); j++) begin
            @(posedge clk); #1;
            e = exp_q[j];
            checks++;
            if ({busy, note_enable, done} !== {e.bz, e.en, e.dn}) begin
                errors++;
                $display("FAIL %s cyc%0d busy/en/done got %b%b%b exp %b%b%b",
                         name, j, busy, note_enable, done, e.bz, e.en, e.dn);
            end
            if (e.play) begin
                checks++;
                if (note_value !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc%0d note_value got %0d exp %0d", name, j, note_value, e.val);
                end
            end
            start = (rand_start && e.bz) ? 1'($urandom) : 1'b0;
        end
        start = 1'b0;
        exp_q.delete();
    endtask

    task automatic expect_idle(input string name);
        checks++;
        if ({busy, note_enable, done, note_value} !== 18'd0) begin
            errors++;
            $display("FAIL %s busy/en/done/value got %b%b%b/%0d exp 000/0",
                     name, busy, note_enable, done, note_value);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 20'd0;
        repeat (3) @(posedge clk);
        #1;
        expect_idle("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_idle("after_reset");
    endtask

    task automatic load_directed();
        write_entry(0, 15'd28408, 5'd2);
        write_entry(1, 15'd20408, 5'd1);
        write_entry(2, 15'd12345, 5'd0);
    endtask

    task automatic test_directed();
        load_directed();
        gen_pass(1'b1, 1'b0);
        repeat (2) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 15'd0));
        run_check("directed", 1'b1);
    endtask

    task automatic test_rest();
        write_entry(0, 15'd0, 5'd3);
        write_entry(1, 15'd999, 5'd0);
        gen_pass(1'b1, 1'b0);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 15'd0));
        run_check("rest", 1'b0);
    endtask

    task automatic test_random_songs();
        int p;
        for (int it = 0; it < 4; it++) begin
            p = int'($urandom_range(1, 5));
            for (int i = 0; i < p; i++) begin
                write_entry(i, ($urandom_range(0, 3) == 0) ? 15'd0 : 15'($urandom_range(1, 32767)),
                            5'($urandom_range(1, 3)));
            end
            write_entry(p, 15'($urandom), 5'd0);
            gen_pass(1'b1, 1'b0);
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 15'd0));
            run_check("random", 1'b1);
        end
    endtask

    task automatic test_full_table();
        for (int i = 0; i < 32; i++) write_entry(i, 15'(i * 100 + 7), 5'($urandom_range(1, 2)));
        gen_pass(1'b1, 1'b0);
        repeat (3) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 15'd0));
        run_check("full_table", 1'b1);
    endtask

    task automatic test_stop();
        load_directed();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (note_enable !== 1'b1) begin
            errors++;
            $display("FAIL stop_pre note_enable got %b exp 1", note_enable);
        end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        expect_idle("stop_play");
        repeat (3) begin
            @(posedge clk); #1;
            expect_idle("stop_after");
        end
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        expect_idle("start_stop");
        @(posedge clk); #1;
        expect_idle("start_stop_after");
    endtask

    task automatic test_reset_midplay();
        load_directed();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_idle("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        gen_pass(1'b1, 1'b0);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 15'd0));
        run_check("replay", 1'b0);
    endtask

    task automatic test_loop();
        load_directed();
        loop = 1'b1;
`ifdef SONG_LOOP_EN
        gen_pass(1'b1, 1'b1);
        gen_pass(1'b0, 1'b1);
        run_check("loop", 1'b0);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        expect_idle("loop_stop");
`else
        gen_pass(1'b1, 1'b0);
        repeat (2) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 15'd0));
        run_check("no_loop", 1'b0);
`endif
        loop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_rest();
        test_random_songs();
        test_full_table();
        test_stop();
        test_reset_midplay();
        test_loop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 Parameter BEAT_DIV, default 25000000, SHALL set clock cycles per beat (>=2).
REQ-002 Parameter GAP_CYCLES, default 1000000, SHALL set silent cycles between notes (>=1, <BEAT_DIV).
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 start  in  1  SHALL be a level pulse that begins playback from entry 0.
REQ-006 stop  in  1  SHALL abort playback.
REQ-007 loop  in  1  SHALL request restart at entry 0 after the song ends (see Configuration).
REQ-008 wr_en  in  1  SHALL be the note-table write strobe.
REQ-009 wr_addr  in  5  SHALL be the note-table write address.
REQ-010 wr_data  in  20  SHALL be the entry: [19:5] half-period value, [4:0] duration in beats.
REQ-011 note_value  out  15  SHALL be the half-period value for the tone generator.
REQ-012 note_enable  out  1  SHALL enable the tone generator.
REQ-013 busy  out  1  SHALL be high in every state except IDLE.
REQ-014 done  out  1  SHALL be a one-cycle pulse at song end.

Function
REQ-015 The note table SHALL hold 32 x 20-bit entries, with synchronous read and read-before-write on same-address collision.
REQ-016 The FSM SHALL have states IDLE, FETCH, PLAY, GAP; all outputs SHALL be registered.
REQ-017 IDLE: start=1 and stop=0 SHALL set addr=0 and go to FETCH; note_enable SHALL rise exactly 2 cycles after start is sampled.
REQ-018 FETCH: duration=0 (terminator) SHALL end the song; otherwise the FSM SHALL load note_value, load the beat counter with duration, and go to PLAY.
REQ-019 PLAY: note_enable=1 when value!=0; value=0 is a rest with note_enable=0. PLAY SHALL last exactly duration*BEAT_DIV cycles.
REQ-020 GAP: note_enable=0 for exactly GAP_CYCLES cycles; the FSM SHALL then increment addr and go to FETCH.
REQ-021 Address wrap: after entry 31 completes its GAP, the song SHALL end (no wrap to 0 except via loop).
REQ-022 Song end: done=1 for one cycle, note_enable=0, then go to IDLE, or to FETCH with addr=0 if looping is active.
REQ-023 stop=1 in any state SHALL force IDLE next cycle with note_enable=0, note_value=0, and no done pulse; stop SHALL take priority over a simultaneous start.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 Table writes SHALL be accepted in every state; a written entry takes effect when it is next fetched.
REQ-026 Beat and gap counters SHALL be 32-bit and SHALL neither overflow nor wrap within any legal parameterisation.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, addr=0, all counters=0, note_value=0, note_enable=0, busy=0, done=0, including mid-note.
REQ-028 Table contents SHALL be unaffected by reset.

Configuration
REQ-029 When macro SONG_LOOP_EN is defined, loop=1 sampled at song end SHALL restart at entry 0 without passing through IDLE (busy stays 1); done SHALL still pulse.
REQ-030 Without SONG_LOOP_EN, the loop port SHALL exist but be ignored, and song end SHALL always return to IDLE.

Verification (BEAT_DIV=4, GAP_CYCLES=2)
REQ-031 Table {0:(28408,2), 1:(20408,1), 2:(x,0)}, pulse start -> note_enable high 2 cycles later, note_value=28408 for 8 cycles, 2 low, 20408 for 4 cycles, 2 low, done pulse, busy=0.
REQ-032 Entry 0 = (0,3) then terminator -> note_enable stays 0 for 12 cycles; busy=1 throughout; then done.
REQ-033 stop asserted during PLAY, and separately start+stop in the same cycle in IDLE -> next cycle IDLE, all outputs 0, no done pulse.
REQ-034 rst_n low mid-PLAY -> outputs 0 asynchronously; table preserved; a subsequent start replays the identical sequence.
REQ-035 All 32 entries non-zero duration -> song ends after entry 31; done pulses once.
REQ-036 SONG_LOOP_EN defined, loop=1 -> entry 0 refetched after the terminator, busy never drops, done pulses each pass; without the macro -> IDLE.
